// File: rtl/cwp_pkg.sv
// cwp_pkg: shared FSM state codes, operation encoding and default window geometry
package cwp_pkg;
    localparam int CWP_NWIN = 8;
    localparam int CWP_CWPW = 3;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CHECK = 2'd1;
    localparam logic [1:0] TRAP  = 2'd2;
    typedef enum logic [1:0] {OP_NOP, OP_SAVE, OP_RESTORE} op_t;
endpackage

// File: rtl/cwp_step.sv
// cwp_step: modulo-NWIN increment/decrement of the window pointer (NWIN = 2**CWPW, so wrap is natural)
module cwp_step #(
    parameter int CWPW = cwp_pkg::CWP_CWPW
) (
    input  logic [CWPW-1:0] cwp,
    output logic [CWPW-1:0] cwp_inc,
    output logic [CWPW-1:0] cwp_dec
);
    // wrap-around falls out of the truncated CWPW-bit arithmetic
    always_comb begin
        cwp_inc = cwp + CWPW'(1);
        cwp_dec = cwp - CWPW'(1);
    end
endmodule

// File: rtl/cwp_window_ctrl.sv
// cwp_window_ctrl: owns CWP and WIM, runs SAVE/RESTORE with window overflow/underflow traps
// Optional: define CWP_TRAP_CNT_EN to add saturating ovf_cnt/unf_cnt trap-entry counters.
module cwp_window_ctrl
    import cwp_pkg::*;
#(
    parameter int NWIN    = CWP_NWIN,
    parameter int CWPW    = CWP_CWPW,
    parameter int CWP_RST = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            op_valid,
    input  logic            op_save,
    input  logic            op_restore,
    output logic            op_ready,
    output logic            op_done,
    output logic            trap_req,
    output logic            trap_ovf,
    input  logic            trap_ack,
    input  logic            cwp_wr_en,
    input  logic [CWPW-1:0] cwp_wr_data,
    input  logic            wim_wr_en,
    input  logic [NWIN-1:0] wim_wr_data,
`ifdef CWP_TRAP_CNT_EN
    output logic [7:0]      ovf_cnt,
    output logic [7:0]      unf_cnt,
`endif
    output logic [CWPW-1:0] cwp,
    output logic [CWPW-1:0] cwp_inc,
    output logic [CWPW-1:0] cwp_dec,
    output logic [NWIN-1:0] wim
);
    logic [1:0]      state;
    op_t             op;
    logic [CWPW-1:0] tgt;
    logic            trap_hit;

    cwp_step #(.CWPW(CWPW)) u_step (
        .cwp     (cwp),
        .cwp_inc (cwp_inc),
        .cwp_dec (cwp_dec)
    );

    // target window and trap decision for the operation held in CHECK (uses pre-write WIM)
    always_comb begin
        tgt      = op == OP_SAVE ? cwp_dec : cwp_inc;
        trap_hit = state == CHECK && !cwp_wr_en && op != OP_NOP && wim[tgt];
        op_ready = state == IDLE;
        trap_req = state == TRAP;
    end

    // FSM, CWP/WIM registers; a direct CWP write overrides any commit and aborts CHECK/TRAP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            op       <= OP_NOP;
            cwp      <= CWPW'(CWP_RST);
            wim      <= '0;
            op_done  <= 1'b0;
            trap_ovf <= 1'b0;
        end else begin
            op_done <= 1'b0;
            if (wim_wr_en) wim <= wim_wr_data;
            if (state == IDLE && op_valid) begin
                op    <= op_save && !op_restore ? OP_SAVE : op_restore && !op_save ? OP_RESTORE : OP_NOP;
                state <= CHECK;
            end else if (state == CHECK) begin
                state <= trap_hit ? TRAP : IDLE;
                if (trap_hit) trap_ovf <= op == OP_SAVE;
                if (!trap_hit && !cwp_wr_en) begin
                    op_done <= 1'b1;
                    if (op != OP_NOP) cwp <= tgt;
                end
            end else if (state == TRAP && (trap_ack || cwp_wr_en)) begin
                state <= IDLE;
            end
            if (cwp_wr_en) cwp <= cwp_wr_data;
        end
    end

`ifdef CWP_TRAP_CNT_EN
    // saturating per-type trap-entry counters, cleared by a direct CWP write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt <= '0;
            unf_cnt <= '0;
        end else if (cwp_wr_en) begin
            ovf_cnt <= '0;
            unf_cnt <= '0;
        end else if (trap_hit) begin
            if (op == OP_SAVE && ovf_cnt != 8'hff) ovf_cnt <= ovf_cnt + 8'd1;
            if (op == OP_RESTORE && unf_cnt != 8'hff) unf_cnt <= unf_cnt + 8'd1;
        end
    end
`endif
endmodule
